timer_cmd_serializer: RTL and testbench
=======================================

Name: timer_cmd_serializer

Overview:
- Upstream driver for the serial-pattern timer: accepts parallel 4-bit delay commands, queues them, and serializes each as a frame on the timer's `data` line.
- Frame = preamble 1101 followed by the delay, MSB first.
- After each frame, waits for the timer's `done`, then returns a one-cycle `ack` before launching the next frame.
- Frames are therefore strictly one-at-a-time.

Parameters:
- FIFO_DEPTH, 4, command queue entries; power of two, ≥2.
- IDLE_GAP, 2, cycles of data=0 driven before each frame; ≥1, so the timer's pattern search starts clean.
- WDOG_CYCLES, 20000, done-timeout in cycles; used only with TIMER_WDOG_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_delay  in  4  delay value for the timer.
- cmd_ready  out  1  queue can accept; equals !full.
- data  out  1  serial line to the timer; registered.
- done  in  1  timer finished; level, held until ack.
- ack  out  1  one-cycle acknowledge to the timer; registered.
- busy  out  1  FSM not in IDLE, or queue not empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries queued.
- frames_done  out  8  completed frames; wraps 255→0.

Behaviour:
- Reset values: data=0, ack=0, cmd_ready=1, busy=0, fifo_level=0, frames_done=0, FSM=IDLE.
- Reset mid-operation: queue flushed, in-flight frame dropped, data=0 from the next cycle. The timer shares this reset.
- Push: on cmd_valid && cmd_ready, cmd_delay is written to the queue.
- cmd_ready depends only on registered `full`. There is no same-cycle passthrough when full, even if a pop occurs that cycle.
- Simultaneous push and pop: fifo_level is unchanged.
- FSM states:
  - IDLE: data=0. If the queue is non-empty, pop the head into shift reg {1101, delay} and go to GAP.
  - GAP: data=0 for IDLE_GAP cycles, then go to SEND.
  - SEND: 8 cycles driving bits 1,1,0,1,d3,d2,d1,d0, one per cycle; then go to WAIT_DONE.
  - WAIT_DONE: data=0. `done` is sampled only in this state. On done=1, go to ACK.
  - ACK: ack=1 for exactly one cycle; frames_done+1; then go to IDLE.
- `done` asserted outside WAIT_DONE is ignored.
- Latency from an empty, idle block: command accepted at edge T → pop at T+1 → first data bit visible T+2+IDLE_GAP.
- Total data-line occupancy per frame is IDLE_GAP+8 cycles.
- Back-to-back: the next frame's GAP starts the cycle after ACK+IDLE, so there are no extra dead cycles beyond IDLE.
- data is low in every state except SEND, so no spurious 1101 is ever generated.
- frames_done increments only in ACK and uses 8-bit wrap arithmetic.

Optional Feature:
- TIMER_WDOG_EN defined:
  - A cycle counter of width $clog2(WDOG_CYCLES+1) runs in WAIT_DONE.
  - If it reaches WDOG_CYCLES without done, the FSM returns to IDLE with no ack and frames_done unchanged.
  - Sticky output `wdog_err` (1 bit, reset 0, cleared only by reset) is set.
- TIMER_WDOG_EN undefined: WAIT_DONE waits indefinitely, and the wdog_err port and counter are absent.

Decomposition:
- Package timer_cmd_pkg: state enum {IDLE, GAP, SEND, WAIT_DONE, ACK}, PREAMBLE=4'b1101, FRAME_BITS=8.
- One sub-module, cmd_fifo: synchronous FIFO parameterized by width/depth, providing full/empty/level.

Test Plan:
- Single command, IDLE_GAP=2: push delay=4'b1010 at cycle 0 → data=0 at cycles 1–3; 1,1,0,1,1,0,1,0 at cycles 4–11; then 0 until done. Check the exact cycle of each bit.
- Done handshake: assert done 50 cycles into WAIT_DONE → ack=1 exactly one cycle later for one cycle; frames_done=1; done ignored if raised during SEND.
- Queue full: push 5 commands back-to-back with depth 4 → cmd_ready=0 after 4th push; 5th held until first pop; all 5 frames emitted in order with correct delays.
- Wrap: complete 256 frames with an auto-done responder → frames_done returns to 0.
- Reset mid-SEND after 3 bits → data=0 next cycle, fifo_level=0, no ack; new command afterward produces a full clean frame.
- Watchdog (TIMER_WDOG_EN, WDOG_CYCLES=100): never assert done → wdog_err=1 at cycle 100 of WAIT_DONE, FSM to IDLE, next queued frame starts.

Source files
------------

// File: rtl/timer_cmd_pkg.sv
// Shared definitions for the serial-pattern timer command serializer.
// Holds the controller state encoding and the frame layout constants.
package timer_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GAP       = 3'd1,
        SEND      = 3'd2,
        WAIT_DONE = 3'd3,
        ACK       = 3'd4
    } state_t;

    // Pattern the timer searches for before it latches a delay nibble.
    localparam logic [3:0] PREAMBLE   = 4'b1101;
    localparam int         FRAME_BITS = 8;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command queue with registered full/empty/level.
// Read data is registered: the popped word appears on rd_data_o the cycle
// after the pop and is held until the next pop.
module cmd_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             push_ok, pop_ok;

    // Requests are qualified here so callers may hold push/pop freely.
    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    // Occupancy bookkeeping; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage write port, kept reset-free so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    // Registered read port; only updates on a pop.
    always_ff @(posedge clk) begin
        if (pop_ok) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    // Pointers and flags; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign rd_data_o = rd_data_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign level_o   = count_q;

endmodule

// File: rtl/timer_cmd_serializer.sv
// Queues 4-bit delay commands and serializes each as a {1101, delay} frame
// on the timer's data line, then waits for done and returns a one-cycle ack.
// Optional done watchdog and sticky wdog_err port: define TIMER_WDOG_EN.
module timer_cmd_serializer
    import timer_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int IDLE_GAP    = 2,
    parameter int WDOG_CYCLES = 20000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    input  logic [3:0]                    cmd_delay,
    output logic                          cmd_ready,
    output logic                          data,
    input  logic                          done,
    output logic                          ack,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    frames_done
`ifdef TIMER_WDOG_EN
    ,
    output logic                          wdog_err
`endif
);

    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);
    localparam logic [2:0]       BIT_LAST = 3'(FRAME_BITS - 1);

    state_t                  state_q, state_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic                    data_q, data_d;
    logic                    ack_q, ack_d;
    logic [7:0]              frames_q, frames_d;

    logic                    fifo_pop;
    logic [3:0]              fifo_rd_data;
    logic                    fifo_full, fifo_empty;

`ifdef TIMER_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
    logic [WD_W-1:0]         wd_cnt_q, wd_cnt_d;
    logic                    wdog_err_q, wdog_err_d;
`endif

    cmd_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (cmd_valid),
        .wr_data_i (cmd_delay),
        .pop_i     (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    // Frame sequencing. The head is popped in IDLE; because the queue read is
    // registered, the word is loaded into the shifter on the GAP->SEND
    // transition, which is always at least one cycle after the pop.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = 1'b0;
        ack_d     = 1'b0;
        frames_d  = frames_q;
        fifo_pop  = 1'b0;
`ifdef TIMER_WDOG_EN
        wd_cnt_d   = wd_cnt_q;
        wdog_err_d = wdog_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    shift_d   = {PREAMBLE, fifo_rd_data};
                    bit_cnt_d = '0;
                    state_d   = SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            SEND: begin
                data_d    = shift_q[FRAME_BITS-1];
                shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_LAST) begin
                    state_d = WAIT_DONE;
`ifdef TIMER_WDOG_EN
                    wd_cnt_d = '0;
`endif
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    ack_d    = 1'b1;
                    frames_d = frames_q + 8'd1;
                    state_d  = ACK;
                end
`ifdef TIMER_WDOG_EN
                else if (wd_cnt_q == WD_LAST) begin
                    wdog_err_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset also drops any in-flight frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= 1'b0;
            ack_q     <= 1'b0;
            frames_q  <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            frames_q  <= frames_d;
        end
    end

`ifdef TIMER_WDOG_EN
    // Done-timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q   <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wd_cnt_q   <= wd_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`endif

    assign cmd_ready   = !fifo_full;
    assign data        = data_q;
    assign ack         = ack_q;
    assign busy        = (state_q != IDLE) || !fifo_empty;
    assign frames_done = frames_q;

endmodule

// File: tb/tb_timer_cmd_serializer.sv
// Scoreboard bench for timer_cmd_serializer: accepted commands queue their
// expected frames; a monitor decodes the data line and ack and checks them.
module tb_timer_cmd_serializer;

    localparam int IDLE_GAP = 2;
    localparam int DEPTH    = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_delay = 4'd0;
    logic       cmd_ready, data, ack, busy;
    logic [2:0] fifo_level;
    logic [7:0] frames_done;
    logic       done;
    logic       done_man = 1'b0;
    logic       done_auto = 1'b0;
    logic       auto_done = 1'b0;
`ifdef TIMER_WDOG_EN
    logic       wdog_err;
`endif

    assign done = auto_done ? done_auto : done_man;

    timer_cmd_serializer #(
        .FIFO_DEPTH  (DEPTH),
        .IDLE_GAP    (IDLE_GAP),
        .WDOG_CYCLES (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_delay   (cmd_delay),
        .cmd_ready   (cmd_ready),
        .data        (data),
        .done        (done),
        .ack         (ack),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .frames_done (frames_done)
`ifdef TIMER_WDOG_EN
        ,
        .wdog_err    (wdog_err)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard and monitor state
    logic [3:0] exp_q[$];
    int         rx_frames = 0;
    int         served = 0;
    logic [7:0] exp_frames = 8'd0;
    logic       mon_in = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_bits = 8'd0;
    int         zero_run = IDLE_GAP;
    logic       prev_ack = 1'b0;
    logic [3:0] mon_exp;

    // Monitor: decode frames from the data line and check every ack pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_in     = 1'b0;
                zero_run   = IDLE_GAP;
                rx_frames  = 0;
                exp_frames = 8'd0;
                prev_ack   = 1'b0;
            end else begin
                if (ack) begin
                    check("ack_single_cycle", prev_ack, 0);
                    exp_frames = exp_frames + 8'd1;
                    check("frames_done_on_ack", frames_done, exp_frames);
                end
                prev_ack = ack;
                if (!mon_in) begin
                    if (data) begin
                        check("gap_before_frame", (zero_run >= IDLE_GAP), 1);
                        mon_in   = 1'b1;
                        mon_bits = 8'd1;
                        mon_cnt  = 1;
                    end else begin
                        zero_run++;
                    end
                end else begin
                    mon_bits = {mon_bits[6:0], data};
                    mon_cnt++;
                    if (mon_cnt == 8) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL frame_unexpected: got frame %b expected none", mon_bits);
                        end else begin
                            mon_exp = exp_q.pop_front();
                            check("frame_preamble", mon_bits[7:4], 4'b1101);
                            check("frame_delay", mon_bits[3:0], mon_exp);
                            $display("frame %0d: bits=%b expected delay=%b", rx_frames, mon_bits, mon_exp);
                        end
                        rx_frames++;
                        mon_in   = 1'b0;
                        zero_run = 0;
                    end
                end
            end
        end
    end

    // Auto responder: raise done after each received frame, drop it on ack.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                done_auto = 1'b0;
                served    = 0;
            end else if (!auto_done) begin
                done_auto = 1'b0;
                served    = rx_frames;
            end else if (!done_auto && served < rx_frames) begin
                done_auto = 1'b1;
            end else if (done_auto && ack) begin
                done_auto = 1'b0;
                served++;
            end
        end
    end

    // Offer one command at a negedge, hold until accepted, return at the
    // negedge right after the accepting edge.
    task automatic push_cmd(input logic [3:0] d, output int waited);
        waited    = 0;
        cmd_valid = 1'b1;
        cmd_delay = d;
        while (!cmd_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            check("push_accept_timeout", 0, 1);
        end else begin
            @(posedge clk);
            exp_q.push_back(d);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int t;
        t = 0;
        while ((busy || ack || exp_q.size() != 0) && t < bound) begin
            @(negedge clk);
            t++;
        end
        check("idle_reached", (t < bound), 1);
    endtask

    logic [7:0] frame1 = 8'b1101_1010;
    logic       ok;
    logic       saw_ack;
    int         w;

    initial begin
        // Reset values
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", data, 0);
        check("rst_ack", ack, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_frames_done", frames_done, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single command, exact bit timing (accepting edge is cycle 0)
        push_cmd(4'b1010, w);
        check("t1_cycle0_data", data, 0);
        check("t1_cycle0_level", fifo_level, 1);
        check("t1_cycle0_busy", busy, 1);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k <= 3) check($sformatf("t1_data_c%0d", k), data, 0);
            else        check($sformatf("t1_data_c%0d", k), data, frame1[11-k]);
            if (k == 1) check("t1_popped_level", fifo_level, 0);
        end
        ok = 1'b1;
        for (int k = 12; k <= 61; k++) begin
            @(negedge clk);
            if (data !== 1'b0 || ack !== 1'b0) ok = 1'b0;
        end
        check("t1_wait_done_quiet", ok, 1);
        done_man = 1'b1;
        @(negedge clk);
        check("t1_ack_after_done", ack, 1);
        check("t1_frames_done", frames_done, 1);
        done_man = 1'b0;
        @(negedge clk);
        check("t1_ack_dropped", ack, 0);
        wait_idle(100);

        // done raised during SEND must be ignored
        push_cmd(4'b0110, w);
        repeat (4) @(negedge clk);
        done_man = 1'b1;
        repeat (4) @(negedge clk);
        done_man = 1'b0;
        saw_ack = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ack) saw_ack = 1'b1;
        end
        check("t2_no_ack_from_send_done", saw_ack, 0);
        check("t2_frames_unchanged", frames_done, 1);
        done_man = 1'b1;
        saw_ack = 1'b0;
        for (int k = 0; k < 10 && !saw_ack; k++) begin
            @(negedge clk);
            if (ack) saw_ack = 1'b1;
        end
        check("t2_ack_seen", saw_ack, 1);
        check("t2_frames_done", frames_done, 2);
        done_man = 1'b0;
        wait_idle(100);

        // Queue full: a frame in flight, then five back-to-back commands
        auto_done = 1'b1;
        @(negedge clk);
        push_cmd(4'h3, w);
        @(negedge clk);
        check("t3_first_popped", fifo_level, 0);
        push_cmd(4'h9, w);
        push_cmd(4'h5, w);
        push_cmd(4'hC, w);
        push_cmd(4'h0, w);
        check("t3_ready_low_when_full", cmd_ready, 0);
        check("t3_level_full", fifo_level, DEPTH);
        push_cmd(4'hF, w);
        check("t3_fifth_held", (w > 0), 1);
        wait_idle(1000);
        check("t3_frames_done", frames_done, 8);

        // Reset in the middle of SEND, with a second command still queued
        push_cmd(4'b0111, w);
        push_cmd(4'b1000, w);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("t4_data_low", data, 0);
        check("t4_level_flushed", fifo_level, 0);
        check("t4_no_ack", ack, 0);
        check("t4_not_busy", busy, 0);
        check("t4_frames_cleared", frames_done, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        push_cmd(4'b0101, w);
        wait_idle(200);
        check("t4_clean_frame", frames_done, 1);

        // Wrap: 255 more frames brings the count back to zero
        for (int i = 0; i < 255; i++) begin
            push_cmd(4'(i), w);
        end
        wait_idle(20000);
        check("t5_frames_wrapped", frames_done, 0);

`ifdef TIMER_WDOG_EN
        // Watchdog: no done at all, two frames time out
        auto_done = 1'b0;
        @(negedge clk);
        push_cmd(4'hA, w);
        push_cmd(4'h6, w);
        w = 0;
        while (!wdog_err && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("t6_wdog_err_set", wdog_err, 1);
        check("t6_wdog_latency", (w > 100 && w < 120), 1);
        wait_idle(500);
        check("t6_frames_unchanged", frames_done, 0);
        check("t6_wdog_sticky", wdog_err, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute bound on simulation time
    initial begin
        #2000000;
        errors++;
        $display("FAIL global_timeout: got no completion expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
